// File: rtl/serm.sv
// Parallel-to-serial word player for the bit-serial SHA-256 datapath.
// One-word skid register feeds a shift register that emits one bit per bclk fall.
module serm #(
    parameter int w_word    = 32,
    parameter bit lsb_first = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bclk,
    input  logic [w_word-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last
);
    localparam int CW = $clog2(w_word + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(w_word - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic              bclk_prev;
    logic              fall;
    logic              accept;
    logic              hold_full;
    logic [w_word-1:0] hold;
    logic [w_word-1:0] sh;
    logic [CW-1:0]     cnt;

    logic              sh_head;
    logic              hold_head;
    logic [w_word-1:0] sh_rest;
    logic [w_word-1:0] hold_rest;

    assign fall     = bclk_prev & ~bclk;
    assign in_ready = ~hold_full;
    assign accept   = in_valid & ~hold_full;

    // Bit order is fixed at elaboration: head is the bit played next, rest is what remains.
    generate
        if (lsb_first) begin : g_lsb
            assign sh_head   = sh[0];
            assign hold_head = hold[0];
            assign sh_rest   = {1'b0, sh[w_word-1:1]};
            assign hold_rest = {1'b0, hold[w_word-1:1]};
        end else begin : g_msb
            assign sh_head   = sh[w_word-1];
            assign hold_head = hold[w_word-1];
            assign sh_rest   = {sh[w_word-2:0], 1'b0};
            assign hold_rest = {hold[w_word-2:0], 1'b0};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_prev <= 1'b0;
            hold_full <= 1'b0;
            hold      <= '0;
            sh        <= '0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            bclk_prev <= bclk;
            if (accept) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end
            // accept and the load below are exclusive: accept needs hold_full low, load needs it high
            if (fall) begin
                if (cnt != '0) begin
                    out       <= sh_head;
                    sh        <= sh_rest;
                    cnt       <= cnt - ONE;
                    out_valid <= 1'b1;
                    out_first <= 1'b0;
                    out_last  <= (cnt == ONE);
                end else if (hold_full) begin
                    out       <= hold_head;
                    sh        <= hold_rest;
                    cnt       <= LOAD_CNT;
                    hold_full <= 1'b0;
                    out_valid <= 1'b1;
                    out_first <= 1'b1;
                    out_last  <= 1'b0;
                end else begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_serm.sv
// Bench for serm: LSB-first and MSB-first instances share stimulus and are
// compared against a word/bit-index model plus hand-derived expectations.
module tb_serm;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bclk = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;

    logic in_ready_l, out_l, out_valid_l, out_first_l, out_last_l;
    logic in_ready_m, out_m, out_valid_m, out_first_m, out_last_m;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serm #(.w_word(W), .lsb_first(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .out(out_l), .out_valid(out_valid_l),
        .out_first(out_first_l), .out_last(out_last_l)
    );

    serm #(.w_word(W), .lsb_first(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .out(out_m), .out_valid(out_valid_m),
        .out_first(out_first_m), .out_last(out_last_m)
    );

    // Reference: a pending word slot plus the current word and how many of its bits were played.
    logic         m_prev, m_pend_full, m_valid, m_first, m_last, m_out_l, m_out_m;
    logic [W-1:0] m_pend, m_cur;
    int           m_idx;
    wire          m_fall  = m_prev && !bclk;
    wire          m_ready = !m_pend_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev <= 1'b0; m_pend_full <= 1'b0; m_pend <= '0; m_cur <= '0; m_idx <= W;
            m_valid <= 1'b0; m_first <= 1'b0; m_last <= 1'b0; m_out_l <= 1'b0; m_out_m <= 1'b0;
        end else begin
            m_prev <= bclk;
            if (in_valid && !m_pend_full) begin
                m_pend <= in_data;
                m_pend_full <= 1'b1;
            end
            if (m_fall) begin
                if (m_idx < W) begin
                    m_out_l <= m_cur[5'(m_idx)];
                    m_out_m <= m_cur[5'(W - 1 - m_idx)];
                    m_valid <= 1'b1; m_first <= 1'b0; m_last <= (m_idx == W - 1);
                    m_idx   <= m_idx + 1;
                end else if (m_pend_full) begin
                    m_cur   <= m_pend;
                    m_out_l <= m_pend[0];
                    m_out_m <= m_pend[W-1];
                    m_valid <= 1'b1; m_first <= 1'b1; m_last <= 1'b0;
                    m_idx   <= 1;
                    m_pend_full <= 1'b0;
                end else begin
                    m_out_l <= 1'b0; m_out_m <= 1'b0;
                    m_valid <= 1'b0; m_first <= 1'b0; m_last <= 1'b0;
                end
            end
        end
    end

    wire [9:0] obs_vec = {out_l, out_m, out_valid_l, out_first_l, out_last_l,
                          out_valid_m, out_first_m, out_last_m, in_ready_l, in_ready_m};
    wire [9:0] mdl_vec = {m_out_l, m_out_m, m_valid, m_first, m_last,
                          m_valid, m_first, m_last, m_ready, m_ready};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One bclk period: finishes the previous low phase, high for 2 clk, then the fall edge.
    task automatic bit_period;
        tick;
        bclk = 1'b1;
        tick;
        tick;
        bclk = 1'b0;
        tick;
    endtask

    // Present a word and hold in_valid until the model says it is taken; in_valid is left high.
    task automatic offer(input logic [W-1:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!m_ready && n < 2000) begin
            tick;
            n++;
        end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL offer_timeout got=in_ready low for %0d clk want=accept", n);
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_vec !== 10'b0000000011) begin
            bad++; $display("FAIL reset_state got=%b want=%b", obs_vec, 10'b0000000011);
        end
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        offer(32'h8000_0001);
        in_valid = 1'b0;
        for (int i = 0; i < 33; i++) begin
            bit_period;
            total++;
            if (obs_vec !== mdl_vec) begin
                bad++; $display("FAIL single_model fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
            end
            total++;
            if ({out_valid_l, out_l, out_first_l, out_last_l} !== {i < 32, i == 0 || i == 31, i == 0, i == 31}) begin
                bad++; $display("FAIL single_bits fall=%0d got=%b want=%b", i + 1,
                                {out_valid_l, out_l, out_first_l, out_last_l},
                                {i < 32, i == 0 || i == 31, i == 0, i == 31});
            end
        end
    endtask

    task automatic test_back_to_back;
        fork
            begin
                offer(32'hFFFF_FFFF);
                offer(32'h0000_0000);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 65; i++) begin
                    bit_period;
                    total++;
                    if (obs_vec !== mdl_vec) begin
                        bad++; $display("FAIL b2b_model fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
                    end
                    total++;
                    if ({out_valid_l, out_l, out_first_l, out_last_l} !==
                        {i < 64, i < 32, i == 0 || i == 32, i == 31 || i == 63}) begin
                        bad++; $display("FAIL b2b_bits fall=%0d got=%b want=%b", i + 1,
                                        {out_valid_l, out_l, out_first_l, out_last_l},
                                        {i < 64, i < 32, i == 0 || i == 32, i == 31 || i == 63});
                    end
                end
            end
        join
    endtask

    task automatic test_backpressure;
        logic [W-1:0]   w0 = $urandom, w1 = $urandom, w2 = $urandom;
        logic [3*W-1:0] stream = '0;
        int             nvalid = 0, nfirst = 0;
        fork
            begin
                offer(w0);
                offer(w1);
                total++;
                if (in_ready_l !== 1'b0) begin
                    bad++; $display("FAIL bp_ready_low got=%b want=0", in_ready_l);
                end
                offer(w2);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 97; i++) begin
                    bit_period;
                    total++;
                    if (obs_vec !== mdl_vec) begin
                        bad++; $display("FAIL bp_model fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
                    end
                    if (out_valid_l) begin
                        stream = {out_l, stream[3*W-1:1]};
                        nvalid++;
                    end
                    if (out_first_l) nfirst++;
                end
            end
        join
        total++;
        if (stream !== {w2, w1, w0} || nvalid != 96 || nfirst != 3) begin
            bad++; $display("FAIL bp_words got=%h bits=%0d words=%0d want=%h bits=96 words=3",
                            stream, nvalid, nfirst, {w2, w1, w0});
        end
    endtask

    task automatic test_msb_first;
        offer(32'h0000_0003);
        in_valid = 1'b0;
        for (int i = 0; i < 33; i++) begin
            bit_period;
            total++;
            if (obs_vec !== mdl_vec) begin
                bad++; $display("FAIL msb_model fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
            end
            total++;
            if ({out_valid_m, out_m, out_first_m, out_last_m} !== {i < 32, i == 30 || i == 31, i == 0, i == 31}) begin
                bad++; $display("FAIL msb_bits fall=%0d got=%b want=%b", i + 1,
                                {out_valid_m, out_m, out_first_m, out_last_m},
                                {i < 32, i == 30 || i == 31, i == 0, i == 31});
            end
        end
    endtask

    task automatic test_reset_mid_word;
        logic [W-1:0] a = $urandom, b = $urandom;
        fork
            begin
                offer(a);
                offer(b);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    bit_period;
                    total++;
                    if (obs_vec !== mdl_vec) begin
                        bad++; $display("FAIL rst_pre_model fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
                    end
                end
            end
        join
        total++;
        if (in_ready_l !== 1'b0 || out_valid_l !== 1'b1) begin
            bad++; $display("FAIL rst_pre_state got=%b%b want=01", in_ready_l, out_valid_l);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_vec !== 10'b0000000011) begin
            bad++; $display("FAIL rst_mid_state got=%b want=%b", obs_vec, 10'b0000000011);
        end
        tick; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit_period;
            total++;
            if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0 || obs_vec !== mdl_vec) begin
                bad++; $display("FAIL rst_post_idle fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_stall;
        logic [W-1:0] w = $urandom, got = '0;
        offer(w);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_period;
            got = {out_l, got[W-1:1]};
        end
        for (int k = 0; k < 50; k++) begin
            tick;
            total++;
            if (obs_vec !== mdl_vec || {out_valid_l, out_l, out_first_l, out_last_l} !== {1'b1, w[9], 2'b00}) begin
                bad++; $display("FAIL stall_frozen clk=%0d got=%b want=%b bit=%b", k, obs_vec, mdl_vec, w[9]);
            end
        end
        for (int i = 10; i < 33; i++) begin
            bit_period;
            total++;
            if (obs_vec !== mdl_vec) begin
                bad++; $display("FAIL stall_model fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
            end
            if (out_valid_l) got = {out_l, got[W-1:1]};
        end
        total++;
        if (got !== w) begin
            bad++; $display("FAIL stall_word got=%h want=%h", got, w);
        end
    endtask

    task automatic test_simultaneous;
        logic [W-1:0] w = $urandom, got = '0;
        tick;
        bclk = 1'b1;
        tick; tick;
        bclk = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        tick;
        in_valid = 1'b0;
        total++;
        if (out_valid_l !== 1'b0 || in_ready_l !== 1'b0 || obs_vec !== mdl_vec) begin
            bad++; $display("FAIL simul_idle got=%b want=%b", obs_vec, mdl_vec);
        end
        for (int i = 0; i < 33; i++) begin
            bit_period;
            total++;
            if (obs_vec !== mdl_vec || out_first_l !== (i == 0) || out_valid_l !== (i < 32)) begin
                bad++; $display("FAIL simul_model fall=%0d got=%b want=%b", i + 1, obs_vec, mdl_vec);
            end
            if (out_valid_l) got = {out_l, got[W-1:1]};
        end
        total++;
        if (got !== w) begin
            bad++; $display("FAIL simul_word got=%h want=%h", got, w);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_msb_first;
        test_reset_mid_word;
        test_stall;
        test_simultaneous;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
